ram_scan_ctrl: RTL
==================

RAM_SCAN_CTRL -- requirements
Module: ram_scan_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, RAM data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, read-data buffer entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  scan request, sampled in IDLE only.
REQ-007 SHALL have port start_addr  input  ADDR_WIDTH  first RAM address.
REQ-008 SHALL have port count  input  ADDR_WIDTH+1  words to read, 0..2^ADDR_WIDTH.
REQ-009 SHALL have port busy  output  1  high outside IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse at scan completion.
REQ-011 SHALL have port EN  output  1  RAM read strobe, one cycle per access.
REQ-012 SHALL have port Address  output  ADDR_WIDTH  RAM address, valid while EN high.
REQ-013 SHALL have port Data_in  output  DATA_WIDTH  RAM write data, driven constant 0.
REQ-014 SHALL have port Valid_out  input  1  RAM read-data valid.
REQ-015 SHALL have port Data_out  input  DATA_WIDTH  RAM read data.
REQ-016 SHALL have port m_valid / m_ready / m_data / m_last  out/in/out/out  1/1/DATA_WIDTH/1  downstream valid/ready stream; m_last marks final word.

Function
REQ-017 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-018 SHALL latch start_addr and count when start is high in IDLE; count 0 goes directly to DONE with no EN.
REQ-019 SHALL, in ISSUE, assert EN for one cycle per word when (fifo_count + outstanding) < FIFO_DEPTH, Address starting at start_addr and incrementing by 1.
REQ-020 SHALL wrap Address from 2^ADDR_WIDTH-1 to 0.
REQ-021 SHALL go ISSUE->DRAIN after the last EN; DRAIN->DONE when outstanding = 0 and FIFO empty; DONE->IDLE after one cycle with done = 1.
REQ-022 SHALL increment outstanding on EN, decrement on Valid_out; simultaneous events leave it unchanged.
REQ-023 SHALL push Data_out into the FIFO on every Valid_out, independent of m_ready; the credit rule of REQ-019 guarantees no overflow.
REQ-024 SHALL present FIFO head on m_data with m_valid high while non-empty; pop when m_valid && m_ready; simultaneous push and pop on a full or empty FIFO SHALL be lossless.
REQ-025 SHALL assert m_last with the word whose delivery count equals latched count.
REQ-026 SHALL ignore start while busy.
REQ-027 SHALL tolerate any RAM read latency >= 1 cycle.

Reset
REQ-028 SHALL, while rst is low, force state IDLE, EN 0, Address 0, Data_in 0, busy 0, done 0, m_valid 0, m_last 0, FIFO empty, outstanding 0.
REQ-029 SHALL abort any scan on reset mid-operation; Valid_out arriving after reset release with no outstanding requests SHALL be dropped.

Configuration
REQ-030 SHALL, with RAM_SCAN_CHECKSUM_EN defined, add output checksum [DATA_WIDTH-1:0] = XOR of all words delivered (m_valid && m_ready) in the current scan, cleared on start, held after done.
REQ-031 SHALL, without RAM_SCAN_CHECKSUM_EN, omit the checksum port and logic entirely.

Verification
REQ-032 SHALL test: start_addr=0, count=4, latency 1, m_ready=1 -> EN on 4 consecutive cycles, Address 0,1,2,3; 4 words out, m_last on 4th, one done pulse.
REQ-033 SHALL test: start_addr=14, count=4 -> Address 14,15,0,1.
REQ-034 SHALL test: count=8, m_ready=0 -> exactly 4 EN pulses then stall; raising m_ready releases the remaining 4; no data lost, order preserved.
REQ-035 SHALL test: count=0 -> no EN, done pulses within 2 cycles of start.
REQ-036 SHALL test: rst low after 2nd EN of count=6 scan -> all outputs reset values; late Valid_out ignored; new scan count=2 delivers exactly 2 words.
REQ-037 SHALL test, with RAM_SCAN_CHECKSUM_EN: data 0x1,0x2,0x4 -> checksum 0x7 after done.

Source files
------------

// File: rtl/ram_scan_ctrl_if.sv
// Bundle of the scan request, RAM read port and downstream stream for ram_scan_ctrl.
// RAM_SCAN_CHECKSUM_EN adds the checksum signal.
interface ram_scan_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH:0]   count;
    logic                  busy;
    logic                  done;
    logic                  EN;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] Data_in;
    logic                  Valid_out;
    logic [DATA_WIDTH-1:0] Data_out;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
`ifdef RAM_SCAN_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum;
`endif

    modport master (
        input  start, start_addr, count, Valid_out, Data_out, m_ready,
        output busy, done, EN, Address, Data_in, m_valid, m_data, m_last
`ifdef RAM_SCAN_CHECKSUM_EN
        , output checksum
`endif
    );

    modport slave (
        output start, start_addr, count, Valid_out, Data_out, m_ready,
        input  busy, done, EN, Address, Data_in, m_valid, m_data, m_last
`ifdef RAM_SCAN_CHECKSUM_EN
        , input checksum
`endif
    );
endinterface

// File: rtl/ram_scan_ctrl.sv
// Reads a run of RAM words and streams them downstream through a credit-limited FIFO.
// Define RAM_SCAN_CHECKSUM_EN to add a running XOR checksum of the delivered words.
module ram_scan_ctrl #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    ram_scan_ctrl_if.master bus_io
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   issue_left_q, issue_left_d;
    logic [ADDR_WIDTH:0]   deliv_q, deliv_d;
    logic [CntW-1:0]       outst_q, outst_d;
    logic [CntW-1:0]       fifo_cnt_q, fifo_cnt_d;
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic            en, push, pop, credit_ok, fifo_empty;
    logic [CntW:0]   in_flight;

    // Words buffered plus words requested never exceed the FIFO, so a push always has room.
    assign in_flight  = {1'b0, fifo_cnt_q} + {1'b0, outst_q};
    assign credit_ok  = int'(unsigned'(in_flight)) < int'(FIFO_DEPTH);
    assign fifo_empty = (fifo_cnt_q == '0);

    assign en   = (state_q == StIssue) && credit_ok;
    // Responses with nothing outstanding belong to a scan aborted by reset.
    assign push = bus_io.Valid_out && (outst_q != '0);
    assign pop  = !fifo_empty && bus_io.m_ready;

    assign bus_io.EN      = en;
    assign bus_io.Address = addr_q;
    assign bus_io.Data_in = '0;
    assign bus_io.busy    = (state_q != StIdle);
    assign bus_io.done    = (state_q == StDone);
    assign bus_io.m_valid = !fifo_empty;
    assign bus_io.m_data  = mem_q[rd_ptr_q];
    assign bus_io.m_last  = !fifo_empty && ((deliv_q + 1'b1) == count_q);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        count_d      = count_q;
        issue_left_d = issue_left_q;
        deliv_d      = deliv_q;
        if (pop) begin
            deliv_d = deliv_q + 1'b1;
        end
        case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    addr_d       = bus_io.start_addr;
                    count_d      = bus_io.count;
                    issue_left_d = bus_io.count;
                    deliv_d      = '0;
                    state_d      = (bus_io.count == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (en) begin
                    addr_d       = addr_q + 1'b1;
                    issue_left_d = issue_left_q - 1'b1;
                    if (issue_left_q == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (outst_q == '0 && fifo_empty) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        case ({en, push})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            count_q      <= '0;
            issue_left_q <= '0;
            deliv_q      <= '0;
            outst_q      <= '0;
            fifo_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            issue_left_q <= issue_left_d;
            deliv_q      <= deliv_d;
            outst_q      <= outst_d;
            fifo_cnt_q   <= fifo_cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: the occupancy count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus_io.Data_out;
        end
    end

`ifdef RAM_SCAN_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q == StIdle && bus_io.start) begin
            csum_d = '0;
        end else if (pop) begin
            csum_d = csum_q ^ mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign bus_io.checksum = csum_q;
`endif

endmodule
